// File: rtl/ifid_hazard_ctrl.sv
// IF/ID pipeline register with load-use / external stall and redirect flush control.
// Optional PERF_CNT_EN macro adds saturating stall and redirect counters.
module ifid_hazard_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_fetch_pc,
  input  logic [31:0] i_fetch_instr,
  input  logic        i_pcsrc,
  input  logic        i_idex_memread,
  input  logic [4:0]  i_idex_rt,
  input  logic        i_ext_stall,
  output logic        o_pcWrite,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_instr,
  output logic        o_ifid_valid,
  output logic        o_idex_bubble,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       load_use;
  logic       load_en;
  logic       flush_en;

  assign load_use = o_ifid_valid & i_idex_memread & (i_idex_rt != 5'd0) &
                    ((i_idex_rt == o_ifid_instr[25:21]) | (i_idex_rt == o_ifid_instr[20:16]));

  // A redirect always wins: the target PC must load even while a stall is requested.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    o_pcWrite     = 1'b1;
    o_idex_bubble = 1'b0;
    load_en       = 1'b0;
    flush_en      = 1'b0;
    case (state)
      RUN: begin
        if (i_pcsrc) begin
          flush_en      = 1'b1;
          o_idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            cnt_next   = FLUSH_RELOAD;
          end
        end else if (load_use | i_ext_stall) begin
          o_pcWrite     = 1'b0;
          o_idex_bubble = load_use;
        end else begin
          load_en = 1'b1;
        end
      end
      FLUSH: begin
        flush_en = 1'b1;
        if (i_pcsrc) begin
          o_idex_bubble = 1'b1;
          cnt_next      = FLUSH_RELOAD;
        end else if (cnt == 3'd0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The pc field is left untouched on a flush; decode ignores it while valid is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ifid_pc    <= 32'd0;
      o_ifid_instr <= NOP_INSTR;
      o_ifid_valid <= 1'b0;
    end else if (flush_en) begin
      o_ifid_instr <= NOP_INSTR;
      o_ifid_valid <= 1'b0;
    end else if (load_en) begin
      o_ifid_pc    <= i_fetch_pc;
      o_ifid_instr <= i_fetch_instr;
      o_ifid_valid <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic stall_inc;

  assign stall_inc = (state == RUN) & (load_use | i_ext_stall) & ~i_pcsrc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= 16'd0;
      o_flush_cnt <= 16'd0;
    end else begin
      if (stall_inc && (o_stall_cnt != 16'hFFFF)) o_stall_cnt <= o_stall_cnt + 16'd1;
      if (i_pcsrc && (o_flush_cnt != 16'hFFFF))   o_flush_cnt <= o_flush_cnt + 16'd1;
    end
  end
`else
  assign o_stall_cnt = 16'd0;
  assign o_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed bench for ifid_hazard_ctrl (FLUSH_CYCLES=2); expected IF/ID contents are
// queued when each step is driven and compared after the capturing edge.
module tb_ifid_hazard_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        pcsrc;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        ext_stall;
  logic        pc_write;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        idex_bubble;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int vectors     = 0;
  int miscompares = 0;
  ifid_exp_t exp_q[$];

  ifid_hazard_ctrl #(.FLUSH_CYCLES(2), .NOP_INSTR(32'h0000_0000)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fetch_pc     (fetch_pc),
    .i_fetch_instr  (fetch_instr),
    .i_pcsrc        (pcsrc),
    .i_idex_memread (idex_memread),
    .i_idex_rt      (idex_rt),
    .i_ext_stall    (ext_stall),
    .o_pcWrite      (pc_write),
    .o_ifid_pc      (ifid_pc),
    .o_ifid_instr   (ifid_instr),
    .o_ifid_valid   (ifid_valid),
    .o_idex_bubble  (idex_bubble),
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive_idle();
    fetch_pc     = 32'd0;
    fetch_instr  = 32'd0;
    pcsrc        = 1'b0;
    idex_memread = 1'b0;
    idex_rt      = 5'd0;
    ext_stall    = 1'b0;
  endtask

  // One clock step: drive at negedge, check combinational controls, then check IF/ID after the edge.
  task automatic apply_stimulus(input string tag,
                                input logic [31:0] f_pc, input logic [31:0] f_instr,
                                input logic p_src, input logic memread, input logic [4:0] rt,
                                input logic ext,
                                input logic e_pcw, input logic e_bub,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_valid);
    ifid_exp_t e;
    @(negedge clk);
    fetch_pc     = f_pc;
    fetch_instr  = f_instr;
    pcsrc        = p_src;
    idex_memread = memread;
    idex_rt      = rt;
    ext_stall    = ext;
    #1;
    check_output({tag, ".pcWrite"}, {31'd0, pc_write}, {31'd0, e_pcw});
    check_output({tag, ".bubble"}, {31'd0, idex_bubble}, {31'd0, e_bub});
    exp_q.push_back('{pc: e_pc, instr: e_instr, valid: e_valid});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_output({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
    check_output({tag, ".instr"}, ifid_instr, e.instr);
    if (e.valid) check_output({tag, ".pc"}, ifid_pc, e.pc);
  endtask

  localparam logic [31:0] INS_A   = 32'h2001_0005;
  localparam logic [31:0] INS_B   = 32'h2002_0007;
  localparam logic [31:0] INS_C   = 32'h0022_1820;
  localparam logic [31:0] INS_ADD = 32'h0041_1820;
  localparam logic [31:0] INS_Z   = 32'h0000_1820;
  localparam logic [31:0] INS_F   = 32'h3c08_1234;
  localparam logic [31:0] INS_G   = 32'h3508_5678;
  localparam logic [31:0] INS_H   = 32'h1000_0003;
  localparam logic [31:0] INS_I   = 32'h2009_0001;
  localparam logic [31:0] INS_J   = 32'h200a_0002;

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #2;
    check_output("reset.valid", {31'd0, ifid_valid}, 32'd0);
    check_output("reset.instr", ifid_instr, 32'd0);
    check_output("reset.pc", ifid_pc, 32'd0);
    check_output("reset.pcWrite", {31'd0, pc_write}, 32'd1);
    check_output("reset.bubble", {31'd0, idex_bubble}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("stream0", 32'h00, INS_A, 0, 0, 5'd0, 0, 1, 0, 32'h00, INS_A, 1);
    apply_stimulus("stream1", 32'h04, INS_B, 0, 0, 5'd0, 0, 1, 0, 32'h04, INS_B, 1);
    apply_stimulus("stream2", 32'h08, INS_C, 0, 0, 5'd0, 0, 1, 0, 32'h08, INS_C, 1);

    apply_stimulus("lu_load", 32'h0C, INS_ADD, 0, 0, 5'd0, 0, 1, 0, 32'h0C, INS_ADD, 1);
    apply_stimulus("lu_stall", 32'h10, INS_Z, 0, 1, 5'd2, 0, 0, 1, 32'h0C, INS_ADD, 1);
    apply_stimulus("lu_resume", 32'h10, INS_Z, 0, 0, 5'd0, 0, 1, 0, 32'h10, INS_Z, 1);
    apply_stimulus("lu_rt0", 32'h14, INS_A, 0, 1, 5'd0, 0, 1, 0, 32'h14, INS_A, 1);

    apply_stimulus("ext_pre", 32'h20, INS_F, 0, 0, 5'd0, 0, 1, 0, 32'h20, INS_F, 1);
    for (int i = 0; i < 3; i++)
      apply_stimulus($sformatf("ext_hold%0d", i), 32'h24, INS_G, 0, 0, 5'd0, 1, 0, 0, 32'h20, INS_F, 1);
    apply_stimulus("ext_release", 32'h24, INS_G, 0, 0, 5'd0, 0, 1, 0, 32'h24, INS_G, 1);

    apply_stimulus("redir_take", 32'h28, INS_H, 1, 0, 5'd0, 0, 1, 1, 32'h0, 32'h0, 0);
    apply_stimulus("redir_flush", 32'h28, INS_H, 0, 0, 5'd0, 0, 1, 0, 32'h0, 32'h0, 0);
    apply_stimulus("redir_target", 32'h100, INS_I, 0, 0, 5'd0, 0, 1, 0, 32'h100, INS_I, 1);

    apply_stimulus("redir_ext_take", 32'h104, INS_J, 1, 0, 5'd0, 1, 1, 1, 32'h0, 32'h0, 0);
    apply_stimulus("redir_ext_flush", 32'h104, INS_J, 0, 0, 5'd0, 1, 1, 0, 32'h0, 32'h0, 0);
    apply_stimulus("redir_ext_target", 32'h200, INS_J, 0, 0, 5'd0, 0, 1, 0, 32'h200, INS_J, 1);

    apply_stimulus("restart_take", 32'h204, INS_A, 1, 0, 5'd0, 0, 1, 1, 32'h0, 32'h0, 0);
    apply_stimulus("restart_again", 32'h204, INS_A, 1, 0, 5'd0, 0, 1, 1, 32'h0, 32'h0, 0);
    apply_stimulus("restart_flush", 32'h300, INS_B, 0, 0, 5'd0, 0, 1, 0, 32'h0, 32'h0, 0);
    apply_stimulus("restart_target", 32'h300, INS_B, 0, 0, 5'd0, 0, 1, 0, 32'h300, INS_B, 1);

`ifdef PERF_CNT_EN
    check_output("perf.stall_cnt", {16'd0, stall_cnt}, 32'd4);
    check_output("perf.flush_cnt", {16'd0, flush_cnt}, 32'd4);
`else
    check_output("perf.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check_output("perf.flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif

    apply_stimulus("rst_pre_flush", 32'h304, INS_C, 1, 0, 5'd0, 0, 1, 1, 32'h0, 32'h0, 0);
    #2;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_output("midrst.valid", {31'd0, ifid_valid}, 32'd0);
    check_output("midrst.instr", ifid_instr, 32'd0);
    check_output("midrst.pc", ifid_pc, 32'd0);
    check_output("midrst.pcWrite", {31'd0, pc_write}, 32'd1);
    check_output("midrst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check_output("midrst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("post_rst_load", 32'h400, INS_I, 0, 0, 5'd0, 0, 1, 0, 32'h400, INS_I, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
